gray_frame_sequencer: RTL and testbench

// - Job controller for the grayscale accelerator datapath. Software sets src/dst/count through the AXI4-Lite

---
 rtl/gray_seq_pkg.sv | 14 +
 rtl/gray_frame_sequencer_if.sv | 39 +++
 rtl/gray_seq_fifo.sv | 52 +++++
 rtl/gray_frame_sequencer.sv | 142 ++++++++++++++
 tb/tb_gray_frame_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_seq_pkg.sv
// Shared types and constants for the gray frame sequencer.
// Imported by the interface, the result FIFO and the top.
package gray_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } seq_state_e;

    localparam int PIX_BYTES = 4;
    localparam int GRAY_PAD  = 24;

endpackage

// File: rtl/gray_frame_sequencer_if.sv
// Memory-side read/write ports and datapath taps of the sequencer.
// master = sequencer, slave = read engine, write engine and datapath.
interface gray_frame_sequencer_if #(
    parameter int ADDR_WIDTH = 32
) ();

    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [ADDR_WIDTH-1:0] rd_req_addr;
    logic                  rd_data_valid;
    logic [31:0]           rd_data;
    logic                  dp_in_valid;
    logic [31:0]           dp_in_data;
    logic                  dp_out_valid;
    logic [7:0]            dp_out_gray;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;

    modport master (
        output rd_req_valid, rd_req_addr,
        input  rd_req_ready, rd_data_valid, rd_data,
        output dp_in_valid, dp_in_data,
        input  dp_out_valid, dp_out_gray,
        output wr_valid, wr_addr, wr_data,
        input  wr_ready
    );

    modport slave (
        input  rd_req_valid, rd_req_addr,
        output rd_req_ready, rd_data_valid, rd_data,
        input  dp_in_valid, dp_in_data,
        output dp_out_valid, dp_out_gray,
        input  wr_valid, wr_addr, wr_data,
        output wr_ready
    );

endinterface

// File: rtl/gray_seq_fifo.sv
// Synchronous first-word-fall-through result buffer.
// Push and pop may coincide, including when full.
module gray_seq_fifo
    import gray_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign count   = wptr_q - rptr_q;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (wptr_q == rptr_q);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push)
                wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)
                rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/gray_frame_sequencer.sv
// Job controller: issues pixel reads, buffers gray results, writes them out.
// Read credits bound in-flight pixels to the result buffer depth.
module gray_frame_sequencer
    import gray_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int DP_LATENCY = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    input  logic [ADDR_WIDTH-1:0] cfg_src_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_dst_addr,
    input  logic [CNT_WIDTH-1:0]  cfg_num_pixels,
    output logic                  sts_busy,
    output logic                  sts_done,
    output logic                  sts_aborted,
    output logic                  irq,
    gray_frame_sequencer_if.master bus
);

    localparam int CRW = $clog2(FIFO_DEPTH) + 1;

    if (DP_LATENCY < 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("gray_frame_sequencer: bad parameters");
    end

    seq_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  num_q, issued_q, written_q;
    logic [CRW-1:0]        credits_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
    logic                  abort_q, done_q, aborted_q, irq_q;
    logic                  rd_hs, wr_hs;
    logic [7:0]            fifo_dout;
    logic                  fifo_full, fifo_empty;
    logic [CRW-1:0]        fifo_count;

    gray_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (ACLK),
        .rst   (ARESET),
        .push  (bus.dp_out_valid),
        .din   (bus.dp_out_gray),
        .pop   (wr_hs),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.rd_req_valid = (state_q == RUN) &&
                              (issued_q != num_q) &&
                              (credits_q != CRW'(FIFO_DEPTH)) &&
                              !fifo_full;
    assign bus.rd_req_addr  = rd_addr_q;
    assign bus.dp_in_valid  = bus.rd_data_valid;
    assign bus.dp_in_data   = bus.rd_data;
    assign bus.wr_valid     = !fifo_empty;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = fifo_empty ? '0 :
                              {{GRAY_PAD{1'b0}}, fifo_dout};

    assign rd_hs = bus.rd_req_valid && bus.rd_req_ready;
    assign wr_hs = bus.wr_valid && bus.wr_ready;

    assign sts_busy    = (state_q != IDLE);
    assign sts_done    = done_q;
    assign sts_aborted = aborted_q;
    assign irq         = irq_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:
                if (cfg_start && cfg_num_pixels != '0)
                    state_d = RUN;
            RUN:
                if (cfg_abort ||
                    (rd_hs && issued_q == num_q - CNT_WIDTH'(1)))
                    state_d = DRAIN;
            DRAIN:
                if (written_q == issued_q && fifo_count == '0)
                    state_d = IDLE;
            default:
                state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            num_q     <= '0;
            issued_q  <= '0;
            written_q <= '0;
            credits_q <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_q     <= 1'b0;
            credits_q <= credits_q + CRW'(rd_hs) - CRW'(wr_hs);
            if (rd_hs) begin
                issued_q  <= issued_q + CNT_WIDTH'(1);
                rd_addr_q <= rd_addr_q + ADDR_WIDTH'(PIX_BYTES);
            end
            if (wr_hs) begin
                written_q <= written_q + CNT_WIDTH'(1);
                wr_addr_q <= wr_addr_q + ADDR_WIDTH'(PIX_BYTES);
            end
            if (state_q == IDLE && cfg_start) begin
                num_q     <= cfg_num_pixels;
                issued_q  <= '0;
                written_q <= '0;
                rd_addr_q <= cfg_src_addr;
                wr_addr_q <= cfg_dst_addr;
                abort_q   <= 1'b0;
                aborted_q <= 1'b0;
                // An empty job completes immediately without bus traffic.
                done_q    <= (cfg_num_pixels == '0);
                irq_q     <= (cfg_num_pixels == '0);
            end
            if (state_q == RUN && cfg_abort)
                abort_q <= 1'b1;
            if (state_q == DRAIN && state_d == IDLE) begin
                irq_q     <= 1'b1;
                done_q    <= !abort_q;
                aborted_q <= abort_q;
            end
        end
    end

endmodule

// File: tb/tb_gray_frame_sequencer.sv
// Randomized bench: memory/datapath models plus a job-level scoreboard.
// Expected traffic is derived from src/dst/count, independent of the RTL.
module tb_gray_frame_sequencer;

    logic        tb_ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic [31:0] cfg_src_addr = '0;
    logic [31:0] cfg_dst_addr = '0;
    logic [15:0] cfg_num_pixels = '0;
    logic        sts_busy, sts_done, sts_aborted, irq;

    gray_frame_sequencer_if #(.ADDR_WIDTH(32)) bus ();

    gray_frame_sequencer #(
        .ADDR_WIDTH (32),
        .CNT_WIDTH  (16),
        .DP_LATENCY (3),
        .FIFO_DEPTH (8)
    ) dut (
        .ACLK           (tb_ACLK),
        .ARESET         (ARESET),
        .cfg_start      (cfg_start),
        .cfg_abort      (cfg_abort),
        .cfg_src_addr   (cfg_src_addr),
        .cfg_dst_addr   (cfg_dst_addr),
        .cfg_num_pixels (cfg_num_pixels),
        .sts_busy       (sts_busy),
        .sts_done       (sts_done),
        .sts_aborted    (sts_aborted),
        .irq            (irq),
        .bus            (bus)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    int n_pass = 0;
    int n_total = 0;
    bit rd_en = 1, wr_en = 1, rd_rand = 0, wr_rand = 0, lat_rand = 0;
    logic [31:0] rd_log[$], wa_log[$], wd_log[$], rq[$];
    int irq_cnt = 0;
    int out_cnt = 0;
    int max_out = 0;
    logic [8:0] dpp [3];

    function automatic logic [31:0] pix(logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E3779B1;
        return {8'h00, h[31:8]};
    endfunction

    function automatic logic [7:0] gray(logic [31:0] p);
        logic [15:0] v;
        v = 16'(77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]));
        return v[15:8];
    endfunction

    // Expected: reads at src+4i, writes at dst+4i carrying gray(pixel i).
    function automatic int job_errs(logic [31:0] src, logic [31:0] dst,
                                    int n_rd, int n_wr);
        int e;
        e = 0;
        if (rd_log.size() != n_rd) e++;
        else for (int i = 0; i < n_rd; i++)
            if (rd_log[i] !== src + 32'(4 * i)) e++;
        if (wa_log.size() != n_wr) e++;
        else for (int i = 0; i < n_wr; i++)
            if (wa_log[i] !== dst + 32'(4 * i) ||
                wd_log[i] !== {24'h0, gray(pix(src + 32'(4 * i)))}) e++;
        return e;
    endfunction

    always @(posedge tb_ACLK) begin
        #1;
        bus.rd_req_ready = rd_rand ? 1'($urandom_range(0, 1)) : rd_en;
        bus.wr_ready     = wr_rand ? 1'($urandom_range(0, 1)) : wr_en;
    end

    always @(posedge tb_ACLK) begin
        if (ARESET) rq.delete();
        else if (bus.rd_req_valid && bus.rd_req_ready)
            rq.push_back(pix(bus.rd_req_addr));
        #1;
        if (rq.size() > 0 && (!lat_rand || $urandom_range(0, 1) == 1)) begin
            bus.rd_data_valid = 1'b1;
            bus.rd_data = rq.pop_front();
        end else begin
            bus.rd_data_valid = 1'b0;
            bus.rd_data = '0;
        end
    end

    always @(posedge tb_ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < 3; i++) dpp[i] <= '0;
        end else begin
            dpp[0] <= {bus.dp_in_valid, gray(bus.dp_in_data)};
            dpp[1] <= dpp[0];
            dpp[2] <= dpp[1];
        end
    end
    assign bus.dp_out_valid = dpp[2][8];
    assign bus.dp_out_gray  = dpp[2][7:0];

    always @(posedge tb_ACLK) begin
        if (ARESET) begin
            out_cnt = 0;
        end else begin
            if (bus.rd_req_valid && bus.rd_req_ready) begin
                rd_log.push_back(bus.rd_req_addr);
                out_cnt++;
            end
            if (bus.wr_valid && bus.wr_ready) begin
                wa_log.push_back(bus.wr_addr);
                wd_log.push_back(bus.wr_data);
                out_cnt--;
            end
            if (out_cnt > max_out) max_out = out_cnt;
            if (irq) irq_cnt++;
        end
    end

    task automatic tick();
        @(posedge tb_ACLK);
        #2;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wa_log.delete();
        wd_log.delete();
        irq_cnt = 0;
        max_out = 0;
    endtask

    task automatic start_job(logic [31:0] s, logic [31:0] d, logic [15:0] n);
        tick();
        cfg_src_addr = s;
        cfg_dst_addr = d;
        cfg_num_pixels = n;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!sts_busy) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) tick();
        n_total++;
        if ({sts_busy, sts_done, sts_aborted, irq,
             bus.rd_req_valid, bus.wr_valid} !== 6'b0)
            $display("FAIL reset_flags: got %b required 000000",
                     {sts_busy, sts_done, sts_aborted, irq,
                      bus.rd_req_valid, bus.wr_valid});
        else n_pass++;
        n_total++;
        if ({bus.rd_req_addr, bus.wr_addr, bus.wr_data} !== 96'b0)
            $display("FAIL reset_buses: rd=%h wr=%h data=%h required 0",
                     bus.rd_req_addr, bus.wr_addr, bus.wr_data);
        else n_pass++;
        ARESET = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        int e;
        clear_logs();
        rd_en = 1; wr_en = 1;
        start_job(32'h1000, 32'h2000, 16'd4);
        n_total++;
        if (bus.rd_req_valid !== 1'b1 || bus.rd_req_addr !== 32'h1000)
            $display("FAIL basic_first_req: valid=%b addr=%h required 1 00001000",
                     bus.rd_req_valid, bus.rd_req_addr);
        else n_pass++;
        wait_idle(ok);
        e = job_errs(32'h1000, 32'h2000, 4, 4);
        n_total++;
        if (ok !== 1'b1) $display("FAIL basic_timeout: busy stuck, required idle");
        else n_pass++;
        n_total++;
        if (e !== 0) $display("FAIL basic_scoreboard: %0d errors required 0", e);
        else n_pass++;
        n_total++;
        if ({sts_done, sts_aborted, sts_busy} !== 3'b100 || irq_cnt !== 1)
            $display("FAIL basic_status: dab=%b irqs=%0d required 100 1",
                     {sts_done, sts_aborted, sts_busy}, irq_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        int e;
        clear_logs();
        rd_en = 1; wr_en = 0;
        start_job(32'h4000, 32'h8000, 16'd20);
        repeat (50) tick();
        n_total++;
        if (max_out !== 8 || rd_log.size() !== 8 || wa_log.size() !== 0)
            $display("FAIL bp_credit_peak: peak=%0d reads=%0d writes=%0d required 8 8 0",
                     max_out, rd_log.size(), wa_log.size());
        else n_pass++;
        n_total++;
        if (bus.rd_req_valid !== 1'b0 || bus.wr_valid !== 1'b1)
            $display("FAIL bp_stall: rd_valid=%b wr_valid=%b required 0 1",
                     bus.rd_req_valid, bus.wr_valid);
        else n_pass++;
        wr_en = 1;
        wait_idle(ok);
        e = job_errs(32'h4000, 32'h8000, 20, 20);
        n_total++;
        if (!ok || e !== 0 || sts_done !== 1'b1)
            $display("FAIL bp_complete: ok=%b errs=%0d done=%b required 1 0 1",
                     ok, e, sts_done);
        else n_pass++;
    endtask

    task automatic test_abort();
        bit ok;
        int e, exp_n;
        clear_logs();
        rd_en = 1; wr_en = 1;
        start_job(32'h0001_0000, 32'h0002_0000, 16'd100);
        for (int i = 0; i < 200 && rd_log.size() < 10; i++) tick();
        exp_n = rd_log.size() + int'(bus.rd_req_valid && bus.rd_req_ready);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        wait_idle(ok);
        e = job_errs(32'h0001_0000, 32'h0002_0000, exp_n, exp_n);
        n_total++;
        if (exp_n < 10 || exp_n > 11 || !ok)
            $display("FAIL abort_reads: reads=%0d ok=%b required 10..11 1", exp_n, ok);
        else n_pass++;
        n_total++;
        if (e !== 0) $display("FAIL abort_scoreboard: %0d errors required 0", e);
        else n_pass++;
        n_total++;
        if ({sts_aborted, sts_done} !== 2'b10 || irq_cnt !== 1)
            $display("FAIL abort_status: ad=%b irqs=%0d required 10 1",
                     {sts_aborted, sts_done}, irq_cnt);
        else n_pass++;
    endtask

    task automatic test_zero_overlap();
        bit ok;
        int e;
        clear_logs();
        start_job(32'h9000, 32'hA000, 16'd0);
        n_total++;
        if ({sts_done, irq, sts_busy} !== 3'b110)
            $display("FAIL zero_done: done/irq/busy=%b required 110",
                     {sts_done, irq, sts_busy});
        else n_pass++;
        tick();
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        tick();
        n_total++;
        if (irq !== 1'b0 || sts_aborted !== 1'b0 || sts_done !== 1'b1 ||
            rd_log.size() !== 0 || wa_log.size() !== 0 || irq_cnt !== 1)
            $display("FAIL zero_quiet: irq=%b ab=%b done=%b rd=%0d wr=%0d irqs=%0d required 0 0 1 0 0 1",
                     irq, sts_aborted, sts_done, rd_log.size(), wa_log.size(), irq_cnt);
        else n_pass++;
        clear_logs();
        start_job(32'h3000, 32'h5000, 16'd6);
        tick();
        start_job(32'hF000, 32'hE000, 16'd50);
        wait_idle(ok);
        e = job_errs(32'h3000, 32'h5000, 6, 6);
        n_total++;
        if (!ok || e !== 0 || irq_cnt !== 1)
            $display("FAIL overlap_ignored: ok=%b errs=%0d irqs=%0d required 1 0 1",
                     ok, e, irq_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int e;
        clear_logs();
        start_job(32'h6000, 32'h7000, 16'd30);
        repeat (5) tick();
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        n_total++;
        if ({sts_busy, sts_done, sts_aborted, irq, bus.rd_req_valid,
             bus.wr_valid, bus.rd_req_addr, bus.wr_addr, bus.wr_data} !== '0)
            $display("FAIL midreset_outputs: busy=%b rdv=%b wrv=%b wa=%h required all 0",
                     sts_busy, bus.rd_req_valid, bus.wr_valid, bus.wr_addr);
        else n_pass++;
        tick();
        clear_logs();
        start_job(32'h100, 32'h200, 16'd3);
        wait_idle(ok);
        e = job_errs(32'h100, 32'h200, 3, 3);
        n_total++;
        if (!ok || e !== 0 || sts_done !== 1'b1 || irq_cnt !== 1)
            $display("FAIL midreset_rerun: ok=%b errs=%0d done=%b irqs=%0d required 1 0 1 1",
                     ok, e, sts_done, irq_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        bit ok;
        int e, n, peak;
        logic [31:0] s, d;
        rd_rand = 1; wr_rand = 1; lat_rand = 1;
        peak = 0;
        for (int j = 0; j < 6; j++) begin
            clear_logs();
            s = $urandom() & 32'hFFFF_FFFC;
            d = $urandom() & 32'hFFFF_FFFC;
            n = $urandom_range(1, 64);
            start_job(s, d, 16'(n));
            wait_idle(ok);
            e = job_errs(s, d, n, n);
            if (max_out > peak) peak = max_out;
            n_total++;
            if (!ok || e !== 0 || sts_done !== 1'b1 || irq_cnt !== 1)
                $display("FAIL random_job%0d: n=%0d ok=%b errs=%0d done=%b irqs=%0d required 1 0 1 1",
                         j, n, ok, e, sts_done, irq_cnt);
            else n_pass++;
        end
        n_total++;
        if (peak > 8)
            $display("FAIL random_credits: peak=%0d required <=8", peak);
        else n_pass++;
        rd_rand = 0; wr_rand = 0; lat_rand = 0;
    endtask

    initial begin
        bus.rd_req_ready = 1'b0;
        bus.wr_ready = 1'b0;
        bus.rd_data_valid = 1'b0;
        bus.rd_data = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_zero_overlap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
